// File: rtl/sm_regdump_pkg.sv
// Shared types, ASCII constants and helpers for the register-dump transmitter.
// Kept separate so other debug transmitters can reuse the hex formatting.
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND,
        NEXT
    } dumpState_t;

    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    localparam int LINE_LEN = 13;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] nibbleToAscii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_0 + {4'b0000, nibble};
        end
        return ASCII_A + {4'b0000, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface.
// Frame is start, d0..d7 LSB first, stop; each bit lasts BAUD_DIV cycles.
module sm_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clkIn,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    logic              active;
    logic [BAUD_W-1:0] baudCnt;
    logic [3:0]        bitCnt;
    logic [9:0]        shiftReg;

    // Bit 0 of the shift register is always the bit currently on the line
    always_ff @(posedge clkIn) begin
        if (rst) begin
            active   <= 1'b0;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '1;
        end else if (!active) begin
            if (valid) begin
                active   <= 1'b1;
                baudCnt  <= '0;
                bitCnt   <= '0;
                shiftReg <= {1'b1, data, 1'b0};
            end
        end else if (baudCnt == BAUD_LAST) begin
            baudCnt <= '0;
            if (bitCnt == 4'd9) begin
                active <= 1'b0;
            end else begin
                bitCnt   <= bitCnt + 4'd1;
                shiftReg <= {1'b1, shiftReg[9:1]};
            end
        end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
        end
    end

    assign ready = !active;
    assign tx    = active ? shiftReg[0] : 1'b1;

endmodule

// File: rtl/sm_regdump_tx.sv
// Walks regAddr over x0..x(REG_COUNT-1), samples regData and sends one
// "AA:DDDDDDDD\r\n" line per register over the UART.
module sm_regdump_tx #(
    parameter int BAUD_DIV      = 434,
    parameter int SETTLE_CYCLES = 4,
    parameter int REG_COUNT     = 32
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx
);

    import sm_regdump_pkg::*;

    localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]          LAST_ADDR   = 5'(REG_COUNT - 1);
    localparam logic [3:0]          LAST_CHAR   = 4'(LINE_LEN - 1);

    dumpState_t          state, stateNext;
    logic [4:0]          addrReg, addrNext;
    logic [SETTLE_W-1:0] settleCnt, settleNext;
    logic [31:0]         snapshot, snapshotNext;
    logic [3:0]          charIdx, charNext;
    logic                doneReg, doneNext;

    logic [7:0] charData;
    logic [3:0] nibbleSel;
    logic       uartValid;
    logic       uartReady;

    always_ff @(posedge clkIn) begin
        if (rst) begin
            state     <= IDLE;
            addrReg   <= '0;
            settleCnt <= '0;
            snapshot  <= '0;
            charIdx   <= '0;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            addrReg   <= addrNext;
            settleCnt <= settleNext;
            snapshot  <= snapshotNext;
            charIdx   <= charNext;
            doneReg   <= doneNext;
        end
    end

    // Chars 3..10 carry snapshot nibbles 7..0, MSB first
    assign nibbleSel = 4'd10 - charIdx;

    always_comb begin
        charData = COLON;
        case (charIdx)
            4'd0:    charData = nibbleToAscii({3'b000, addrReg[4]});
            4'd1:    charData = nibbleToAscii(addrReg[3:0]);
            4'd2:    charData = COLON;
            4'd11:   charData = CR;
            4'd12:   charData = LF;
            default: charData = nibbleToAscii(snapshot[{nibbleSel[2:0], 2'b00} +: 4]);
        endcase
    end

    always_comb begin
        stateNext    = state;
        addrNext     = addrReg;
        settleNext   = settleCnt;
        snapshotNext = snapshot;
        charNext     = charIdx;
        doneNext     = 1'b0;
        uartValid    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addrNext   = '0;
                    settleNext = SETTLE_LOAD;
                    stateNext  = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt == '0) begin
                    snapshotNext = regData;
                    charNext     = '0;
                    stateNext    = SEND;
                end else begin
                    settleNext = settleCnt - SETTLE_W'(1);
                end
            end
            SEND: begin
                uartValid = 1'b1;
                if (uartReady) begin
                    if (charIdx == LAST_CHAR) begin
                        stateNext = NEXT;
                    end else begin
                        charNext = charIdx + 4'd1;
                    end
                end
            end
            NEXT: begin
                // Ready here means the LF frame has fully left the line
                if (uartReady) begin
                    if (addrReg == LAST_ADDR) begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        addrNext   = addrReg + 5'd1;
                        settleNext = SETTLE_LOAD;
                        stateNext  = SETTLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    sm_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) uartTx (
        .clkIn(clkIn),
        .rst  (rst),
        .data (charData),
        .valid(uartValid),
        .ready(uartReady),
        .tx   (tx)
    );

    assign busy    = (state != IDLE);
    assign done    = doneReg;
    assign regAddr = addrReg;

endmodule

// File: tb/tb_sm_regdump_tx.sv
// Directed bench for sm_regdump_tx and its UART: decodes the serial line
// and compares each dumped line against hand-computed ASCII.
module tb_sm_regdump_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small dump instance (two registers)
    logic        rstA, startA, busyA, doneA, txA;
    logic [4:0]  addrA;
    logic [31:0] dataA, manualData;
    logic        useTable;

    // Full 32-register instance
    logic        rstB, startB, busyB, doneB, txB;
    logic [4:0]  addrB;
    logic [31:0] dataB;

    // Stand-alone UART
    logic       uRst, uValid, uReady, uTx;
    logic [7:0] uData;

    logic sel;
    logic txSel, doneSel, busySel;

    int checks = 0;
    int errors = 0;
    int doneCntA = 0;
    int doneCntB = 0;

    assign dataA   = useTable ? ((addrA == 5'd1) ? 32'hDEADBEEF : 32'h0) : manualData;
    assign dataB   = {27'b0, addrB};
    assign txSel   = sel ? txB : txA;
    assign doneSel = sel ? doneB : doneA;
    assign busySel = sel ? busyB : busyA;

    sm_regdump_tx #(.BAUD_DIV(4), .SETTLE_CYCLES(4), .REG_COUNT(2)) dutA (
        .clkIn(clk), .rst(rstA), .start(startA), .busy(busyA), .done(doneA),
        .regAddr(addrA), .regData(dataA), .tx(txA)
    );

    sm_regdump_tx #(.BAUD_DIV(4), .SETTLE_CYCLES(4), .REG_COUNT(32)) dutB (
        .clkIn(clk), .rst(rstB), .start(startB), .busy(busyB), .done(doneB),
        .regAddr(addrB), .regData(dataB), .tx(txB)
    );

    sm_uart_tx #(.BAUD_DIV(4)) uut (
        .clkIn(clk), .rst(uRst), .data(uData), .valid(uValid), .ready(uReady), .tx(uTx)
    );

    always @(posedge clk) begin
        if (doneA === 1'b1) doneCntA <= doneCntA + 1;
        if (doneB === 1'b1) doneCntB <= doneCntB + 1;
    end

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    function automatic logic [103:0] expLine(input logic [4:0] a, input logic [31:0] d);
        return {hexChar({3'b0, a[4]}), hexChar(a[3:0]), 8'h3A,
                hexChar(d[31:28]), hexChar(d[27:24]), hexChar(d[23:20]), hexChar(d[19:16]),
                hexChar(d[15:12]), hexChar(d[11:8]), hexChar(d[7:4]), hexChar(d[3:0]),
                8'h0D, 8'h0A};
    endfunction

    task automatic checkOutput(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit useB);
        if (useB) startB = 1'b1; else startA = 1'b1;
        @(negedge clk);
        if (useB) startB = 1'b0; else startA = 1'b0;
    endtask

    // Samples each bit in the middle of its 4-cycle window
    task automatic receiveByte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b0;
        b  = 8'h00;
        n  = 0;
        while (txSel !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txSel !== 1'b0) return;
        repeat (2) @(negedge clk);
        if (txSel !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = txSel;
        end
        repeat (4) @(negedge clk);
        ok = (txSel === 1'b1);
    endtask

    task automatic receiveLine(output logic [103:0] line);
        logic [7:0] b;
        bit ok;
        line = '0;
        for (int i = 0; i < 13; i++) begin
            receiveByte(b, ok);
            if (!ok) begin
                line = 'x;
                return;
            end
            line = {line[95:0], b};
        end
    endtask

    task automatic waitDone(output bit seen);
        int n;
        n = 0;
        while (doneSel !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = (doneSel === 1'b1);
    endtask

    logic [103:0] line0, line1;
    logic [39:0]  capVec, expVec;
    logic [9:0]   frameBits;
    logic [7:0]   rxByte;
    bit           rxOk, seen;
    int           base, lows, lowReady;

    initial begin
        rstA = 1'b1; rstB = 1'b1; uRst = 1'b1;
        startA = 1'b0; startB = 1'b0;
        uValid = 1'b0; uData = 8'h00;
        useTable = 1'b1; manualData = 32'h0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rstA = 1'b0; rstB = 1'b0; uRst = 1'b0;
        @(negedge clk);

        checkOutput("reset tx", txA, 1'b1);
        checkOutput("reset busy", busyA, 1'b0);
        checkOutput("reset done", doneA, 1'b0);
        checkOutput("reset regAddr", addrA, 5'd0);

        // Single UART frame 0xA5
        checkOutput("uart ready idle", uReady, 1'b1);
        uData = 8'hA5; uValid = 1'b1;
        @(negedge clk);
        uValid = 1'b0;
        frameBits = 10'b1_1010_0101_0;
        lowReady = 0;
        for (int k = 0; k < 40; k++) begin
            expVec[k] = frameBits[k / 4];
            capVec[k] = uTx;
            if (uReady === 1'b0) lowReady++;
            @(negedge clk);
        end
        checkOutput("uart frame bits", capVec, expVec);
        checkOutput("uart ready low cycles", lowReady, 40);
        checkOutput("uart ready back", uReady, 1'b1);
        checkOutput("uart tx idle", uTx, 1'b1);

        // Basic two-register dump
        sel = 1'b0;
        base = doneCntA;
        applyStimulus(1'b0);
        checkOutput("busy after start", busyA, 1'b1);
        receiveLine(line0);
        receiveLine(line1);
        checkOutput("dumpA line0", line0, {"00:00000000", 8'h0D, 8'h0A});
        checkOutput("dumpA line1", line1, {"01:DEADBEEF", 8'h0D, 8'h0A});
        waitDone(seen);
        checkOutput("dumpA done seen", seen, 1'b1);
        checkOutput("dumpA busy with done", busyA, 1'b0);
        @(negedge clk);
        checkOutput("dumpA done pulse width", doneA, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("dumpA done count", doneCntA - base, 1);

        // Snapshot hold: regData changes right after the x0 capture edge
        useTable = 1'b0;
        manualData = 32'h12345678;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (4) @(negedge clk);
        manualData = 32'hCAFEF00D;
        receiveLine(line0);
        receiveLine(line1);
        checkOutput("snapshot line0", line0, {"00:12345678", 8'h0D, 8'h0A});
        checkOutput("snapshot line1", line1, {"01:CAFEF00D", 8'h0D, 8'h0A});
        waitDone(seen);
        checkOutput("snapshot done", seen, 1'b1);
        useTable = 1'b1;
        repeat (5) @(negedge clk);

        // Repeated start pulses while busy
        base = doneCntA;
        applyStimulus(1'b0);
        fork
            begin
                receiveLine(line0);
                receiveLine(line1);
            end
            begin
                repeat (300) begin
                    @(negedge clk);
                    startA = ~startA;
                end
                startA = 1'b0;
            end
        join
        checkOutput("pulsed line0", line0, {"00:00000000", 8'h0D, 8'h0A});
        checkOutput("pulsed line1", line1, {"01:DEADBEEF", 8'h0D, 8'h0A});
        waitDone(seen);
        repeat (50) @(negedge clk);
        checkOutput("pulsed done count", doneCntA - base, 1);
        checkOutput("pulsed idle after", busyA, 1'b0);

        // Start held high re-triggers right after done
        startA = 1'b1;
        receiveLine(line0);
        receiveLine(line1);
        waitDone(seen);
        checkOutput("held done seen", seen, 1'b1);
        checkOutput("held busy low at done", busyA, 1'b0);
        @(negedge clk);
        checkOutput("held busy restarts", busyA, 1'b1);
        startA = 1'b0;
        receiveLine(line0);
        checkOutput("held second dump line0", line0, {"00:00000000", 8'h0D, 8'h0A});
        waitDone(seen);
        repeat (5) @(negedge clk);

        // Reset during char 5 of the third line on the 32-register instance
        sel = 1'b1;
        applyStimulus(1'b1);
        receiveLine(line0);
        receiveLine(line1);
        checkOutput("dumpB pre-reset line0", line0, expLine(5'd0, 32'd0));
        checkOutput("dumpB pre-reset line1", line1, expLine(5'd1, 32'd1));
        for (int i = 0; i < 5; i++) receiveByte(rxByte, rxOk);
        checkOutput("dumpB char4 of line2", {rxOk, rxByte}, {1'b1, 8'h30});
        lows = 0;
        while (txB !== 1'b0 && lows < 100) begin
            @(negedge clk);
            lows++;
        end
        repeat (6) @(negedge clk);
        rstB = 1'b1;
        @(negedge clk);
        rstB = 1'b0;
        checkOutput("midreset tx", txB, 1'b1);
        checkOutput("midreset busy", busyB, 1'b0);
        checkOutput("midreset regAddr", addrB, 5'd0);
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            if (txB !== 1'b1 || busyB !== 1'b0) lows++;
            @(negedge clk);
        end
        checkOutput("midreset stays quiet", lows, 0);

        // Full 32-register dump after reset
        base = doneCntB;
        applyStimulus(1'b1);
        for (int r = 0; r < 32; r++) begin
            receiveLine(line0);
            checkOutput($sformatf("dumpB line%0d", r), line0, expLine(5'(r), 32'(r)));
        end
        waitDone(seen);
        checkOutput("dumpB done seen", seen, 1'b1);
        checkOutput("dumpB final regAddr", addrB, 5'd31);
        repeat (20) @(negedge clk);
        checkOutput("dumpB done count", doneCntB - base, 1);
        checkOutput("dumpB idle", busyB, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
